// File: rtl/srf_writeback_arbiter_pkg.sv
// Shared constants for the scalar register file writeback path.
package srf_writeback_arbiter_pkg;

  // Register file geometry, shared with the scalar register file itself
  localparam int SRF_BIT_NUMBER      = 32;
  localparam int SRF_ADDR_NUMBER     = 5;
  localparam int SRF_REGISTER_NUMBER = 16;

  // Default number of writeback sources
  localparam int SRF_NUM_REQ = 3;

  // Requester slot assignment on the writeback port
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_VMOV = 2;

endpackage

// File: rtl/srf_writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
// The pointer moves to the slot after the winner; it holds when nobody wins.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Search from the pointer, wrapping modulo N; first requester found wins
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_next   = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/srf_writeback_arbiter.sv
// Writeback arbiter for the scalar register file: round-robin share of the
// single write port, registered output stage, and a busy scoreboard.
module srf_writeback_arbiter
  import srf_writeback_arbiter_pkg::*;
#(
  parameter int BIT_NUMBER      = SRF_BIT_NUMBER,
  parameter int ADDR_NUMBER     = SRF_ADDR_NUMBER,
  parameter int REGISTER_NUMBER = SRF_REGISTER_NUMBER,
  parameter int NUM_REQ         = SRF_NUM_REQ
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_NUMBER-1:0]  req_addr,
  input  logic [NUM_REQ*BIT_NUMBER-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rf_write_enable,
  output logic [ADDR_NUMBER-1:0]          rf_dest_addr,
  output logic [BIT_NUMBER-1:0]           rf_write_data,
  input  logic                            reserve_valid,
  input  logic [ADDR_NUMBER-1:0]          reserve_addr,
  output logic                            reserve_ready,
  output logic [REGISTER_NUMBER-1:0]      busy_mask,
  output logic                            err_addr
);

  logic [NUM_REQ-1:0]         grant;
  logic                       any_grant;
  logic [ADDR_NUMBER-1:0]     sel_addr;
  logic [BIT_NUMBER-1:0]      sel_data;
  logic                       write_legal;
  logic                       reserve_legal;
  logic                       reserve_busy;
  logic [REGISTER_NUMBER-1:0] reserve_onehot;
  logic [REGISTER_NUMBER-1:0] clear_mask;
  logic [REGISTER_NUMBER-1:0] set_mask;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req_valid),
    .grant(grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  // Mux the granted requester's address and data onto the write path
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_NUMBER +: ADDR_NUMBER];
        sel_data = req_data[i*BIT_NUMBER +: BIT_NUMBER];
      end
    end
  end

  // Legality and scoreboard masks; out-of-range shifts yield an empty mask
  always_comb begin
    write_legal    = 32'(sel_addr) < 32'(REGISTER_NUMBER);
    reserve_legal  = 32'(reserve_addr) < 32'(REGISTER_NUMBER);
    reserve_onehot = REGISTER_NUMBER'(1) << reserve_addr;
    reserve_busy   = |(busy_mask & reserve_onehot);
    reserve_ready  = !reset && reserve_valid && reserve_legal && !reserve_busy;
    set_mask       = reserve_ready ? reserve_onehot : '0;
    clear_mask     = rf_write_enable ? (REGISTER_NUMBER'(1) << rf_dest_addr) : '0;
  end

  // Output stage: a legal grant becomes next cycle's write, otherwise addr/data hold
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_dest_addr    <= '0;
      rf_write_data   <= '0;
      err_addr        <= 1'b0;
    end else begin
      rf_write_enable <= any_grant && write_legal;
      if (any_grant && write_legal) begin
        rf_dest_addr  <= sel_addr;
        rf_write_data <= sel_data;
      end
      err_addr <= (any_grant && !write_legal) || (reserve_valid && !reserve_legal);
    end
  end

  // Scoreboard: the outgoing write releases its register, an accepted reservation sets one
  always_ff @(posedge clk) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= (busy_mask & ~clear_mask) | set_mask;
  end

endmodule

// File: tb/tb_srf_writeback_arbiter.sv
// Self-checking bench for srf_writeback_arbiter: directed table, hand-written
// reset sequence, then randomized traffic against a behavioural model.
module tb_srf_writeback_arbiter;
  import srf_writeback_arbiter_pkg::*;

  localparam int N  = SRF_NUM_REQ;
  localparam int AW = SRF_ADDR_NUMBER;
  localparam int DW = SRF_BIT_NUMBER;
  localparam int RN = SRF_REGISTER_NUMBER;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*AW-1:0]  req_addr;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             rf_write_enable;
  logic [AW-1:0]    rf_dest_addr;
  logic [DW-1:0]    rf_write_data;
  logic             reserve_valid;
  logic [AW-1:0]    reserve_addr;
  logic             reserve_ready;
  logic [RN-1:0]    busy_mask;
  logic             err_addr;

  int checks   = 0;
  int failures = 0;

  srf_writeback_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rf_write_enable(rf_write_enable),
    .rf_dest_addr   (rf_dest_addr),
    .rf_write_data  (rf_write_data),
    .reserve_valid  (reserve_valid),
    .reserve_addr   (reserve_addr),
    .reserve_ready  (reserve_ready),
    .busy_mask      (busy_mask),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [N-1:0]  rv;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic          resv;
    logic [AW-1:0] resa;
    logic [N-1:0]  e_ready;
    logic          e_resready;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [RN-1:0] e_busy;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [N-1:0] rv,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic resv, input logic [AW-1:0] resa,
                              input logic [N-1:0] e_ready, input logic e_resready,
                              input logic e_we, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                              input logic [RN-1:0] e_busy, input logic e_err);
    vec_t v;
    v.name = n; v.rv = rv; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.resv = resv; v.resa = resa;
    v.e_ready = e_ready; v.e_resready = e_resready; v.e_we = e_we;
    v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] rv,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic resv, input logic [AW-1:0] resa);
    req_valid     = rv;
    req_addr      = {a2, a1, a0};
    req_data      = {d2, d1, d0};
    reserve_valid = resv;
    reserve_addr  = resa;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference model state
  int            m_ptr;
  bit            m_busy[RN];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_err;

  function automatic logic [RN-1:0] model_busy();
    logic [RN-1:0] b;
    for (int r = 0; r < RN; r++) b[r] = m_busy[r];
    return b;
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    for (int r = 0; r < RN; r++) m_busy[r] = 0;
    m_we = 0; m_addr = '0; m_data = '0; m_err = 0;
  endfunction

  initial begin
    bit            pend[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];
    logic [N-1:0]  rv;
    logic          resv, rst, legal, res_legal, res_ok;
    logic [AW-1:0] resa;
    int            g, idx;

    // Reset: outputs forced low and handshakes suppressed even with requests pending
    reset = 1'b1;
    applyStimulus('1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b1, 5'd4);
    tick(); tick(); tick();
    #2;
    checkOutput("reset req_ready", req_ready, '0);
    checkOutput("reset reserve_ready", reserve_ready, 0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b0, '0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      checkOutput("idle req_ready", req_ready, '0);
      checkOutput("idle we", rf_write_enable, 0);
      checkOutput("idle addr", rf_dest_addr, 0);
      checkOutput("idle data", rf_write_data, 0);
      checkOutput("idle busy", busy_mask, 0);
      checkOutput("idle err", err_addr, 0);
    end

    // Directed table; each row is one cycle, expectations after its edge
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk("rot0", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 0, 5'd0,
                       3'b001, 0, 1, 5'd1, 32'h11111111, 16'h0000, 0));
      tbl.push_back(mk("rot1", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 0, 5'd0,
                       3'b010, 0, 1, 5'd2, 32'h22222222, 16'h0000, 0));
      tbl.push_back(mk("rot2", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 0, 5'd0,
                       3'b100, 0, 1, 5'd3, 32'h33333333, 16'h0000, 0));
    end
    tbl.push_back(mk("single1", 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 5'd0,
                     3'b010, 0, 1, 5'd5, 32'hDEADBEEF, 16'h0000, 0));
    tbl.push_back(mk("idle hold", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0,
                     3'b000, 0, 0, 5'd5, 32'hDEADBEEF, 16'h0000, 0));
    tbl.push_back(mk("reserve r7", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd7,
                     3'b000, 1, 0, 5'd5, 32'hDEADBEEF, 16'h0080, 0));
    tbl.push_back(mk("reserve r7 busy", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd7,
                     3'b000, 0, 0, 5'd5, 32'hDEADBEEF, 16'h0080, 0));
    tbl.push_back(mk("writeback r7", 3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77777777, 0, 5'd0,
                     3'b100, 0, 1, 5'd7, 32'h77777777, 16'h0080, 0));
    tbl.push_back(mk("clear+reserve r7", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd7,
                     3'b000, 0, 0, 5'd7, 32'h77777777, 16'h0000, 0));
    tbl.push_back(mk("retry r7", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd7,
                     3'b000, 1, 0, 5'd7, 32'h77777777, 16'h0080, 0));
    tbl.push_back(mk("illegal write", 3'b001, 5'd20, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 0, 5'd0,
                     3'b001, 0, 0, 5'd7, 32'h77777777, 16'h0080, 1));
    tbl.push_back(mk("err pulse end", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0,
                     3'b000, 0, 0, 5'd7, 32'h77777777, 16'h0080, 0));
    tbl.push_back(mk("illegal reserve", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd16,
                     3'b000, 0, 0, 5'd7, 32'h77777777, 16'h0080, 1));
    tbl.push_back(mk("err pulse end2", 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0,
                     3'b000, 0, 0, 5'd7, 32'h77777777, 16'h0080, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rv, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2,
                    tbl[i].resv, tbl[i].resa);
      #3;
      checkOutput({tbl[i].name, " req_ready"}, req_ready, tbl[i].e_ready);
      checkOutput({tbl[i].name, " reserve_ready"}, reserve_ready, tbl[i].e_resready);
      tick();
      checkOutput({tbl[i].name, " we"}, rf_write_enable, tbl[i].e_we);
      checkOutput({tbl[i].name, " addr"}, rf_dest_addr, tbl[i].e_addr);
      checkOutput({tbl[i].name, " data"}, rf_write_data, tbl[i].e_data);
      checkOutput({tbl[i].name, " busy"}, busy_mask, tbl[i].e_busy);
      checkOutput({tbl[i].name, " err"}, err_addr, tbl[i].e_err);
    end

    // Reset right after a grant to req 2: pending write dropped, pointer back to 0
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99999999, 0, 5'd0);
    #3;
    checkOutput("pre-reset grant", req_ready, 3'b100);
    tick();
    checkOutput("pre-reset we", rf_write_enable, 1);
    reset = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1, 5'd3);
    #3;
    checkOutput("in-reset req_ready", req_ready, '0);
    checkOutput("in-reset reserve_ready", reserve_ready, 0);
    tick();
    checkOutput("post-reset we", rf_write_enable, 0);
    checkOutput("post-reset busy", busy_mask, '0);
    checkOutput("post-reset addr", rf_dest_addr, 0);
    reset = 1'b0;
    #2;
    checkOutput("post-reset first grant", req_ready, 3'b001);
    tick();
    checkOutput("post-reset write addr", rf_dest_addr, 5'd1);
    checkOutput("post-reset write data", rf_write_data, 32'hA);

    // Randomized traffic against the model, starting from a clean reset
    reset = 1'b1;
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 0, '0);
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          pa[i]   = AW'($urandom_range(0, 19));
          pd[i]   = $urandom;
        end
        rv[i] = pend[i];
      end
      resv  = ($urandom_range(0, 1) == 1);
      resa  = AW'($urandom_range(0, 17));
      rst   = ($urandom_range(0, 49) == 0);
      reset = rst;
      applyStimulus(rv, pa[0], pa[1], pa[2], pd[0], pd[1], pd[2], resv, resa);

      g = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && rv[idx]) g = idx;
        end
      end
      res_legal = int'(resa) < RN;
      res_ok    = !rst && resv && res_legal && !m_busy[resa];

      #3;
      checkOutput("rand req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      checkOutput("rand reserve_ready", reserve_ready, res_ok);
      tick();

      if (rst) begin
        model_reset();
      end else begin
        if (m_we) m_busy[m_addr] = 0;
        if (res_ok) m_busy[resa] = 1;
        m_err = resv && !res_legal;
        m_we  = 0;
        if (g >= 0) begin
          pend[g] = 0;
          m_ptr   = (g + 1) % N;
          legal   = int'(pa[g]) < RN;
          if (legal) begin
            m_we   = 1;
            m_addr = pa[g];
            m_data = pd[g];
          end else begin
            m_err = 1;
          end
        end
      end
      checkOutput("rand we", rf_write_enable, m_we);
      checkOutput("rand addr", rf_dest_addr, m_addr);
      checkOutput("rand data", rf_write_data, m_data);
      checkOutput("rand busy", busy_mask, model_busy());
      checkOutput("rand err", err_addr, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
